// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared pipeline types for the ucrv32 memory-access stage: access size,
// memory-stage FSM state, writeback source, and store lane helpers.
// Used by: mem_access, mem_access_load_align.
package mem_access_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_source_type;

  // Byte enables from size and the low address bits. Half uses only addr[1],
  // so a misaligned half still lands on a legal half lane.
  function automatic logic [3:0] lane_be(input mem_size_t size, input logic [1:0] addr);
    case (size)
      MEM_B:   return 4'b0001 << addr;
      MEM_H:   return 4'b0011 << {addr[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across all lanes; byte enables pick the lane.
  function automatic logic [31:0] lane_wdata(input mem_size_t size, input logic [31:0] data);
    case (size)
      MEM_B:   return {4{data[7:0]}};
      MEM_H:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// mem_access_load_align
// Combinational load-data alignment: picks the byte/half lane addressed by
// addr_i and sign- or zero-extends it to 32 bits. Word loads pass through.
// Ports:
//   rdata_i    in  32  raw bus read data
//   addr_i     in  2   low address bits of the access
//   size_i     in  mem_size_t
//   unsigned_i in  1   zero-extend instead of sign-extend
//   data_o     out 32  aligned, extended load value
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{addr_i, 3'b000} +: 8];
    half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      MEM_B:   data_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
      MEM_H:   data_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
// Memory-access stage of the ucrv32 pipeline. Issues loads/stores on a
// req/gnt/rvalid data bus, stalls upstream while a transaction is open,
// aligns load data and registers all results into the MEM/WB boundary.
// Optional build macro: MEM_MISALIGN_CHECK_EN (trap misaligned half/word
// accesses locally instead of issuing them; drives misalign_o).
// Ports:
//   clk_i, rst_i (async, active-high)
//   execute bundle in : valid_i, alu_result_i, rs2_data_i, rd_i, alu_zero_i,
//                       branch_i, jmp_i, memread_en_i, memwrite_en_i,
//                       mem_size_i, mem_unsigned_i, wb_en_i, wb_src_i,
//                       pc_4_i, pc_imm_i
//   stall_o            : hold upstream pipeline register
//   data bus           : dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
//                        dmem_be_o, dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
//   MEM/WB out         : valid_o, wb_en_o, rd_o, wb_src_o, alu_result_o,
//                        load_data_o, pc_4_o, redirect_o, redirect_target_o,
//                        misalign_o
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accept bundle; non-mem ops complete here in one cycle
// ST_REQ  | dmem_req_o high until granted; stores complete on grant
// ST_WAIT | load granted, waiting for rvalid; completes on rvalid
module mem_access
  import mem_access_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [31:0]   alu_result_i,
  input  logic [31:0]   rs2_data_i,
  input  logic [4:0]    rd_i,
  input  logic          alu_zero_i,
  input  logic          branch_i,
  input  logic          jmp_i,
  input  logic          memread_en_i,
  input  logic          memwrite_en_i,
  input  mem_size_t     mem_size_i,
  input  logic          mem_unsigned_i,
  input  logic          wb_en_i,
  input  wb_source_type wb_src_i,
  input  logic [31:0]   pc_4_i,
  input  logic [31:0]   pc_imm_i,
  output logic          stall_o,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [31:0]   dmem_addr_o,
  output logic [31:0]   dmem_wdata_o,
  output logic [3:0]    dmem_be_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [31:0]   dmem_rdata_i,
  output logic          valid_o,
  output logic          wb_en_o,
  output logic [4:0]    rd_o,
  output wb_source_type wb_src_o,
  output logic [31:0]   alu_result_o,
  output logic [31:0]   load_data_o,
  output logic [31:0]   pc_4_o,
  output logic          redirect_o,
  output logic [31:0]   redirect_target_o,
  output logic          misalign_o
);

  mem_state_t state_q, state_d;

  // Transaction latched on entry to ST_REQ
  logic [31:0]   lat_addr_q;
  logic [31:0]   lat_wdata_q;
  logic [3:0]    lat_be_q;
  mem_size_t     lat_size_q;
  logic          lat_uns_q;
  logic          lat_load_q;
  logic [4:0]    lat_rd_q;
  logic          lat_wb_en_q;
  wb_source_type lat_wb_src_q;
  logic [31:0]   lat_pc_4_q;
  logic          lat_redir_q;
  logic [31:0]   lat_target_q;

  // MEM/WB registers
  logic          valid_q;
  logic          wb_en_q;
  logic [4:0]    rd_q;
  wb_source_type wb_src_q;
  logic [31:0]   alu_result_q;
  logic [31:0]   load_data_q;
  logic [31:0]   pc_4_q;
  logic          redirect_q;
  logic [31:0]   target_q;

  logic        mem_op;
  logic        misalign_in;
  logic        start;
  logic        done_store;
  logic        done_load;
  logic        redir_in;
  logic [31:0] load_aligned;

  assign mem_op   = memread_en_i | memwrite_en_i;
  assign redir_in = (branch_i & alu_zero_i) | jmp_i;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_in = valid_i & mem_op &
                       (((mem_size_i == MEM_H) & alu_result_i[0]) |
                        ((mem_size_i == MEM_W) & (alu_result_i[1:0] != 2'b00)));
`else
  assign misalign_in = 1'b0;
`endif

  assign start      = (state_q == ST_IDLE) & valid_i & mem_op & ~misalign_in;
  // rvalid is only looked at in ST_WAIT, so one coincident with grant is dropped
  assign done_store = (state_q == ST_REQ) & dmem_gnt_i & ~lat_load_q;
  assign done_load  = (state_q == ST_WAIT) & dmem_rvalid_i;

  assign stall_o = start
                 | ((state_q == ST_REQ) & ~done_store)
                 | ((state_q == ST_WAIT) & ~done_load);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ:  if (dmem_gnt_i) state_d = lat_load_q ? ST_WAIT : ST_IDLE;
      ST_WAIT: if (dmem_rvalid_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      lat_be_q     <= '0;
      lat_size_q   <= MEM_B;
      lat_uns_q    <= 1'b0;
      lat_load_q   <= 1'b0;
      lat_rd_q     <= '0;
      lat_wb_en_q  <= 1'b0;
      lat_wb_src_q <= WB_ALU;
      lat_pc_4_q   <= '0;
      lat_redir_q  <= 1'b0;
      lat_target_q <= '0;
    end else if (start) begin
      lat_addr_q   <= alu_result_i;
      lat_wdata_q  <= lane_wdata(mem_size_i, rs2_data_i);
      lat_be_q     <= lane_be(mem_size_i, alu_result_i[1:0]);
      lat_size_q   <= mem_size_i;
      lat_uns_q    <= mem_unsigned_i;
      lat_load_q   <= memread_en_i;
      lat_rd_q     <= rd_i;
      lat_wb_en_q  <= wb_en_i;
      lat_wb_src_q <= wb_src_i;
      lat_pc_4_q   <= pc_4_i;
      lat_redir_q  <= redir_in;
      lat_target_q <= pc_imm_i;
    end
  end

  mem_access_load_align u_load_align (
    .rdata_i    (dmem_rdata_i),
    .addr_i     (lat_addr_q[1:0]),
    .size_i     (lat_size_q),
    .unsigned_i (lat_uns_q),
    .data_o     (load_aligned)
  );

  // Data fields hold while stalled; valid/wb_en/redirect are cleared so a
  // held value is never consumed twice downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      wb_en_q      <= 1'b0;
      rd_q         <= '0;
      wb_src_q     <= WB_ALU;
      alu_result_q <= '0;
      load_data_q  <= '0;
      pc_4_q       <= '0;
      redirect_q   <= 1'b0;
      target_q     <= '0;
    end else if ((state_q == ST_IDLE) && valid_i && !start) begin
      valid_q      <= 1'b1;
      wb_en_q      <= wb_en_i & ~misalign_in;
      rd_q         <= rd_i;
      wb_src_q     <= wb_src_i;
      alu_result_q <= alu_result_i;
      pc_4_q       <= pc_4_i;
      redirect_q   <= redir_in;
      target_q     <= pc_imm_i;
    end else if (done_store || done_load) begin
      valid_q      <= 1'b1;
      wb_en_q      <= lat_wb_en_q;
      rd_q         <= lat_rd_q;
      wb_src_q     <= lat_wb_src_q;
      alu_result_q <= lat_addr_q;
      pc_4_q       <= lat_pc_4_q;
      redirect_q   <= lat_redir_q;
      target_q     <= lat_target_q;
      if (done_load) load_data_q <= load_aligned;
    end else begin
      valid_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      redirect_q <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  misalign_q <= 1'b0;
    else if (state_q == ST_IDLE) misalign_q <= misalign_in;
    else                        misalign_q <= 1'b0;
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  assign dmem_req_o   = (state_q == ST_REQ);
  assign dmem_we_o    = dmem_req_o & ~lat_load_q;
  assign dmem_addr_o  = {lat_addr_q[31:2], 2'b00};
  assign dmem_wdata_o = lat_wdata_q;
  assign dmem_be_o    = dmem_req_o ? lat_be_q : 4'b0000;

  assign valid_o           = valid_q;
  assign wb_en_o           = wb_en_q;
  assign rd_o              = rd_q;
  assign wb_src_o          = wb_src_q;
  assign alu_result_o      = alu_result_q;
  assign load_data_o       = load_data_q;
  assign pc_4_o            = pc_4_q;
  assign redirect_o        = redirect_q;
  assign redirect_target_o = target_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
// Directed bench for mem_access: reset state, non-mem pass-through, store
// lanes, load alignment/extension, branch redirect, reset mid-transaction and
// the misaligned-access behaviour of whichever build (MEM_MISALIGN_CHECK_EN).
module tb_mem_access;
  import mem_access_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          valid_i;
  logic [31:0]   alu_result_i;
  logic [31:0]   rs2_data_i;
  logic [4:0]    rd_i;
  logic          alu_zero_i, branch_i, jmp_i;
  logic          memread_en_i, memwrite_en_i;
  mem_size_t     mem_size_i;
  logic          mem_unsigned_i;
  logic          wb_en_i;
  wb_source_type wb_src_i;
  logic [31:0]   pc_4_i, pc_imm_i;
  logic          stall_o, dmem_req_o, dmem_we_o;
  logic [31:0]   dmem_addr_o, dmem_wdata_o;
  logic [3:0]    dmem_be_o;
  logic          dmem_gnt_i, dmem_rvalid_i;
  logic [31:0]   dmem_rdata_i;
  logic          valid_o, wb_en_o;
  logic [4:0]    rd_o;
  wb_source_type wb_src_o;
  logic [31:0]   alu_result_o, load_data_o, pc_4_o;
  logic          redirect_o;
  logic [31:0]   redirect_target_o;
  logic          misalign_o;

  int checks = 0;
  int errors = 0;

  mem_access dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .alu_result_i(alu_result_i),
    .rs2_data_i(rs2_data_i), .rd_i(rd_i), .alu_zero_i(alu_zero_i), .branch_i(branch_i),
    .jmp_i(jmp_i), .memread_en_i(memread_en_i), .memwrite_en_i(memwrite_en_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .wb_en_i(wb_en_i),
    .wb_src_i(wb_src_i), .pc_4_i(pc_4_i), .pc_imm_i(pc_imm_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o),
    .wb_en_o(wb_en_o), .rd_o(rd_o), .wb_src_o(wb_src_o), .alu_result_o(alu_result_o),
    .load_data_o(load_data_o), .pc_4_o(pc_4_o), .redirect_o(redirect_o),
    .redirect_target_o(redirect_target_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_in;
    valid_i = 0; alu_result_i = 0; rs2_data_i = 0; rd_i = 0;
    alu_zero_i = 0; branch_i = 0; jmp_i = 0;
    memread_en_i = 0; memwrite_en_i = 0; mem_size_i = MEM_B; mem_unsigned_i = 0;
    wb_en_i = 0; wb_src_i = WB_ALU; pc_4_i = 0; pc_imm_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic do_store(input string tag, input logic [31:0] addr, input mem_size_t sz,
                          input logic [31:0] data, input int gnt_wait,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
    int stalls;
    stalls = 0;
    valid_i = 1; memwrite_en_i = 1; alu_result_i = addr; rs2_data_i = data;
    mem_size_i = sz; rd_i = 5'd3;
    #1;
    chk({tag, "_stall0"}, {31'd0, stall_o}, 32'd1);
    chk({tag, "_noreq0"}, {31'd0, dmem_req_o}, 32'd0);
    if (stall_o) stalls++;
    tick;
    chk({tag, "_req"}, {31'd0, dmem_req_o}, 32'd1);
    chk({tag, "_we"}, {31'd0, dmem_we_o}, 32'd1);
    chk({tag, "_addr"}, dmem_addr_o, exp_addr);
    chk({tag, "_be"}, {28'd0, dmem_be_o}, {28'd0, exp_be});
    chk({tag, "_wdata"}, dmem_wdata_o, exp_wd);
    chk({tag, "_vstall"}, {31'd0, valid_o}, 32'd0);
    for (int i = 0; i < gnt_wait; i++) begin
      if (stall_o) stalls++;
      tick;
    end
    chk({tag, "_reqheld"}, {31'd0, dmem_req_o}, 32'd1);
    dmem_gnt_i = 1;
    #1;
    chk({tag, "_stalldone"}, {31'd0, stall_o}, 32'd0);
    tick;
    clr_in;
    chk({tag, "_nstall"}, stalls, gnt_wait + 1);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    chk({tag, "_alures"}, alu_result_o, addr);
    chk({tag, "_reqoff"}, {31'd0, dmem_req_o}, 32'd0);
  endtask

  // Grant and a garbage rvalid in the same cycle, real rvalid one cycle later.
  task automatic do_load(input string tag, input logic [31:0] addr, input mem_size_t sz,
                         input logic uns, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [31:0] exp_data);
    valid_i = 1; memread_en_i = 1; alu_result_i = addr; mem_size_i = sz;
    mem_unsigned_i = uns; rd_i = 5'd7; wb_en_i = 1; wb_src_i = WB_MEM;
    tick;
    chk({tag, "_req"}, {31'd0, dmem_req_o}, 32'd1);
    chk({tag, "_we"}, {31'd0, dmem_we_o}, 32'd0);
    chk({tag, "_addr"}, dmem_addr_o, exp_addr);
    dmem_gnt_i = 1; dmem_rvalid_i = 1; dmem_rdata_i = ~rdata;
    #1;
    chk({tag, "_stallgnt"}, {31'd0, stall_o}, 32'd1);
    tick;
    dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = rdata;
    chk({tag, "_noearly"}, {31'd0, valid_o}, 32'd0);
    #1;
    chk({tag, "_stalldone"}, {31'd0, stall_o}, 32'd0);
    tick;
    clr_in;
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    chk({tag, "_data"}, load_data_o, exp_data);
    chk({tag, "_rd"}, {27'd0, rd_o}, 32'd7);
    chk({tag, "_wben"}, {31'd0, wb_en_o}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    clr_in;
    #2 rst_i = 1;
    tick;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
    rst_i = 0;
    tick;

    // Non-mem op
    valid_i = 1; alu_result_i = 32'h1234; rd_i = 5'd5; wb_en_i = 1; pc_4_i = 32'h104;
    #1;
    chk("nm_stall", {31'd0, stall_o}, 32'd0);
    tick;
    clr_in;
    chk("nm_valid", {31'd0, valid_o}, 32'd1);
    chk("nm_alu", alu_result_o, 32'h1234);
    chk("nm_rd", {27'd0, rd_o}, 32'd5);
    chk("nm_wben", {31'd0, wb_en_o}, 32'd1);
    chk("nm_pc4", pc_4_o, 32'h104);
    chk("nm_stall1", {31'd0, stall_o}, 32'd0);
    tick;
    chk("nm_validoff", {31'd0, valid_o}, 32'd0);

    // Stores
    do_store("stb", 32'h103, MEM_B, 32'h1234_56AB, 2, 32'h100, 4'b1000, 32'hABAB_ABAB);
    do_store("sth", 32'h102, MEM_H, 32'h0000_BEEF, 0, 32'h100, 4'b1100, 32'hBEEF_BEEF);
    do_store("stw", 32'h204, MEM_W, 32'hCAFE_F00D, 1, 32'h204, 4'b1111, 32'hCAFE_F00D);
    do_store("stb0", 32'h0, MEM_B, 32'h0000_005A, 0, 32'h0, 4'b0001, 32'h5A5A_5A5A);

    // Loads
    do_load("lh", 32'h102, MEM_H, 1'b0, 32'h8001_0000, 32'h100, 32'hFFFF_8001);
    do_load("lbu", 32'h101, MEM_B, 1'b1, 32'h0000_8000, 32'h100, 32'h0000_0080);
    do_load("lb", 32'h103, MEM_B, 1'b0, 32'h9A00_0000, 32'h100, 32'hFFFF_FF9A);
    do_load("lw", 32'h200, MEM_W, 1'b0, 32'hDEAD_BEEF, 32'h200, 32'hDEAD_BEEF);
    do_load("lhu", 32'h100, MEM_H, 1'b1, 32'h1234_F00D, 32'h100, 32'h0000_F00D);

    // Branch / jump redirect
    valid_i = 1; branch_i = 1; alu_zero_i = 1; pc_imm_i = 32'h40;
    tick;
    chk("br_taken", {31'd0, redirect_o}, 32'd1);
    chk("br_target", redirect_target_o, 32'h40);
    alu_zero_i = 0; pc_imm_i = 32'h80;
    tick;
    chk("br_nottaken", {31'd0, redirect_o}, 32'd0);
    branch_i = 0; jmp_i = 1;
    tick;
    chk("jmp_taken", {31'd0, redirect_o}, 32'd1);
    chk("jmp_target", redirect_target_o, 32'h80);
    clr_in;
    tick;
    chk("redir_novalid", {31'd0, redirect_o}, 32'd0);

    // Reset while in REQ
    valid_i = 1; memwrite_en_i = 1; alu_result_i = 32'h300; mem_size_i = MEM_W;
    tick;
    clr_in;
    chk("rreq_req", {31'd0, dmem_req_o}, 32'd1);
    #2 rst_i = 1;
    #1;
    chk("rreq_reqdrop", {31'd0, dmem_req_o}, 32'd0);
    chk("rreq_stalldrop", {31'd0, stall_o}, 32'd0);
    rst_i = 0;
    tick;

    // Reset while in WAIT, then a stray rvalid
    valid_i = 1; memread_en_i = 1; alu_result_i = 32'h400; mem_size_i = MEM_W; wb_en_i = 1;
    tick;
    dmem_gnt_i = 1;
    tick;
    clr_in;
    #1;
    chk("rwait_stall", {31'd0, stall_o}, 32'd1);
    #1 rst_i = 1;
    #1;
    chk("rwait_reqdrop", {31'd0, dmem_req_o}, 32'd0);
    chk("rwait_stalldrop", {31'd0, stall_o}, 32'd0);
    rst_i = 0;
    tick;
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h5555_5555;
    tick;
    dmem_rvalid_i = 0;
    chk("rwait_novalid", {31'd0, valid_o}, 32'd0);
    chk("rwait_nostall", {31'd0, stall_o}, 32'd0);
    chk("rwait_nodata", load_data_o, 32'h0);

    // Misaligned word load at 0x101
`ifdef MEM_MISALIGN_CHECK_EN
    valid_i = 1; memread_en_i = 1; alu_result_i = 32'h101; mem_size_i = MEM_W;
    wb_en_i = 1; rd_i = 5'd9;
    #1;
    chk("mis_stall", {31'd0, stall_o}, 32'd0);
    tick;
    clr_in;
    chk("mis_noreq", {31'd0, dmem_req_o}, 32'd0);
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
    chk("mis_wben", {31'd0, wb_en_o}, 32'd0);
    chk("mis_valid", {31'd0, valid_o}, 32'd1);
    tick;
    chk("mis_flagoff", {31'd0, misalign_o}, 32'd0);
`else
    valid_i = 1; memread_en_i = 1; alu_result_i = 32'h101; mem_size_i = MEM_W;
    tick;
    chk("mis_be", {28'd0, dmem_be_o}, 32'hF);
    clr_in;
    dmem_gnt_i = 1;
    tick;
    dmem_gnt_i = 0;
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h1122_3344;
    tick;
    clr_in;
    chk("mis_data", load_data_o, 32'h1122_3344);
    chk("mis_flag", {31'd0, misalign_o}, 32'd0);
    chk("mis_valid", {31'd0, valid_o}, 32'd1);
`endif

    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
